// File: rtl/regfile_master_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_master_if
// Description : Command, response and register-file port bundle for
//               regfile_master. The master modport is the controller side,
//               the slave modport is the requester / register-file side.
// Revision    : 1.0
// ============================================================================
interface regfile_master_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    // Command channel
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_waddr;
    logic [ADDR_W-1:0] req_raddr1;
    logic [ADDR_W-1:0] req_raddr2;
    logic [DATA_W-1:0] req_wdata;

    // Completion channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data1;
    logic [DATA_W-1:0] rsp_data2;

    // Register-file port
    logic              rf_en;
    logic              rf_rd;
    logic              rf_wr;
    logic [ADDR_W-1:0] rf_sel_ip;
    logic [ADDR_W-1:0] rf_sel_op1;
    logic [ADDR_W-1:0] rf_sel_op2;
    logic [DATA_W-1:0] rf_ip;
    logic [DATA_W-1:0] rf_op1;
    logic [DATA_W-1:0] rf_op2;

    modport master (
        input  req_valid, req_op, req_waddr, req_raddr1, req_raddr2, req_wdata,
        input  rsp_ready, rf_op1, rf_op2,
        output req_ready, rsp_valid, rsp_data1, rsp_data2,
        output rf_en, rf_rd, rf_wr, rf_sel_ip, rf_sel_op1, rf_sel_op2, rf_ip
    );

    modport slave (
        output req_valid, req_op, req_waddr, req_raddr1, req_raddr2, req_wdata,
        output rsp_ready, rf_op1, rf_op2,
        input  req_ready, rsp_valid, rsp_data1, rsp_data2,
        input  rf_en, rf_rd, rf_wr, rf_sel_ip, rf_sel_op1, rf_sel_op2, rf_ip
    );
endinterface
`default_nettype wire

// File: rtl/regfile_master.sv
`default_nettype none
// ============================================================================
// Module      : regfile_master
// Description : Sequences single commands (FILL / WRITE / READ / READ_WRITE)
//               onto a register file with registered read data, and returns
//               the read results over a valid/ready completion handshake.
// Revision    : 1.0
// ============================================================================
module regfile_master #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    regfile_master_if.master   bus
);

    localparam logic [1:0]        c_OP_FILL  = 2'b00;
    localparam logic [ADDR_W-1:0] c_SEL_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_SEL_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        FILL    = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              w_accept;
    logic              w_fill_last;

    logic              r_op_rd;      // latched op[1]: command returns read data
    logic [ADDR_W-1:0] r_fill_cnt;   // register being written in this FILL cycle

    logic              r_rf_en;
    logic              r_rf_rd;
    logic              r_rf_wr;
    logic [ADDR_W-1:0] r_rf_sel_ip;
    logic [ADDR_W-1:0] r_rf_sel_op1;
    logic [ADDR_W-1:0] r_rf_sel_op2;
    logic [DATA_W-1:0] r_rf_ip;

    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data1;
    logic [DATA_W-1:0] r_rsp_data2;

    // Ready is held low during reset so nothing is taken while rst is high.
    assign bus.req_ready = (r_state == IDLE) & ~rst;
    assign w_accept      = bus.req_valid & bus.req_ready;
    assign w_fill_last   = (r_fill_cnt == c_SEL_LAST);

    assign bus.rf_en      = r_rf_en;
    assign bus.rf_rd      = r_rf_rd;
    assign bus.rf_wr      = r_rf_wr;
    assign bus.rf_sel_ip  = r_rf_sel_ip;
    assign bus.rf_sel_op1 = r_rf_sel_op1;
    assign bus.rf_sel_op2 = r_rf_sel_op2;
    assign bus.rf_ip      = r_rf_ip;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data1  = r_rsp_data1;
    assign bus.rsp_data2  = r_rsp_data2;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (bus.req_op == c_OP_FILL) ? FILL : ISSUE;
                end
            end
            ISSUE:   w_state_nxt = CAPTURE;
            CAPTURE: w_state_nxt = RESP;
            FILL: begin
                if (w_fill_last) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered register-file strobes, selects and response, driven from the
    // next state so they line up with the cycle in which that state is active.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_rd      <= 1'b0;
            r_fill_cnt   <= '0;
            r_rf_en      <= 1'b0;
            r_rf_rd      <= 1'b0;
            r_rf_wr      <= 1'b0;
            r_rf_sel_ip  <= '0;
            r_rf_sel_op1 <= '0;
            r_rf_sel_op2 <= '0;
            r_rf_ip      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data1  <= '0;
            r_rsp_data2  <= '0;
        end else begin
            r_rf_en     <= (w_state_nxt == ISSUE) || (w_state_nxt == FILL);
            // ISSUE is only ever entered straight from an acceptance, so the
            // live request op is the command being issued.
            r_rf_rd     <= (w_state_nxt == ISSUE) && bus.req_op[1];
            r_rf_wr     <= ((w_state_nxt == ISSUE) && bus.req_op[0]) ||
                           (w_state_nxt == FILL);
            r_rsp_valid <= (w_state_nxt == RESP);

            if (w_accept) begin
                r_op_rd      <= bus.req_op[1];
                r_rf_sel_op1 <= bus.req_raddr1;
                r_rf_sel_op2 <= bus.req_raddr2;
                r_rf_sel_ip  <= (bus.req_op == c_OP_FILL) ? '0 : bus.req_waddr;
                r_rf_ip      <= bus.req_wdata;
                r_fill_cnt   <= '0;
                // FILL and WRITE complete with zero data; reads overwrite
                // this in CAPTURE.
                r_rsp_data1  <= '0;
                r_rsp_data2  <= '0;
            end

            // Step the fill select; it stops on the last register, no wrap.
            if ((r_state == FILL) && !w_fill_last) begin
                r_fill_cnt  <= r_fill_cnt + c_SEL_ONE;
                r_rf_sel_ip <= r_fill_cnt + c_SEL_ONE;
            end

            // Register file presents read data in CAPTURE (read-before-write).
            if (r_state == CAPTURE) begin
                r_rsp_data1 <= r_op_rd ? bus.rf_op1 : '0;
                r_rsp_data2 <= r_op_rd ? bus.rf_op2 : '0;
            end
        end
    end

endmodule
`default_nettype wire
